// File: rtl/hex_sched_pkg.sv
// ---------------------------------------------------------------------------
// hex_sched_pkg
// Shared definitions for the seven-segment frame scheduler:
//   - default geometry (digit count, segments per digit, period width, ...)
//   - BLANK_DIGIT: segment pattern that turns a digit off (active-low drive)
//   - state_e: scheduler states IDLE / COUNT / LOAD
// Optional feature macro used by the scheduler: HEX_BLINK_EN.
// ---------------------------------------------------------------------------
package hex_sched_pkg;

   localparam int DEF_DIGITS     = 4;
   localparam int DEF_SEG_W      = 7;
   localparam int DEF_PERIOD_W   = 28;
   localparam int DEF_MIN_PERIOD = 5;
   localparam int DEF_CNT_W      = 16;

   // Segments are active-low, so all ones is a dark digit.
   localparam logic [DEF_SEG_W-1:0] BLANK_DIGIT = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      LOAD  = 2'd2
   } state_e;

endpackage

// File: rtl/hex_period_timer.sv
// ---------------------------------------------------------------------------
// hex_period_timer
// Frame period counter with expiry compare.
//   clk_clk     in   system clock
//   reset_reset in   synchronous active-high reset
//   period_in   in   requested frame period in cycles (floored to MIN_PERIOD)
//   run         in   0 = hold counter at zero, 1 = count
//   expire      out  high in the cycle whose edge ends the current period
// The effective period is re-evaluated every cycle, and the compare is >=
// so shrinking the period below the running count expires on the next edge.
// ---------------------------------------------------------------------------
module hex_period_timer
   import hex_sched_pkg::*;
#(
   parameter int PERIOD_W   = DEF_PERIOD_W,
   parameter int MIN_PERIOD = DEF_MIN_PERIOD
)(
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic                run,
   output logic                expire
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] eff_period;

   assign eff_period = (period_in < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD)
                                                           : period_in;

   // While the counter is held at zero this can never fire, because the
   // effective period is always at least MIN_PERIOD (> 1).
   assign expire = (cnt_q >= (eff_period - PERIOD_W'(1)));

   always_comb begin
      cnt_d = cnt_q + PERIOD_W'(1);
      if (!run || expire) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hex_frame_sched.sv
// ---------------------------------------------------------------------------
// hex_frame_sched
// Samples the segment decode word once per programmable frame period and
// copies it into the display register one digit per cycle.
//   clk_clk     in   system clock
//   reset_reset in   synchronous active-high reset
//   decode_in   in   segment patterns, digit i = bits [i*SEG_W +: SEG_W]
//   period_in   in   frame period in cycles, 0 = stopped
//   blink_mask  in   per-digit blink enable (only with HEX_BLINK_EN)
//   seg_out     out  registered segment drive, active-low
//   frame_tick  out  one-cycle pulse, first cycle a new frame is fully shown
//   frame_cnt   out  completed-frame count, wraps
// Optional feature: define HEX_BLINK_EN to add blink_mask and a blink phase
// that blanks masked digits on every other frame.
// ---------------------------------------------------------------------------
module hex_frame_sched
   import hex_sched_pkg::*;
#(
   parameter int DIGITS     = DEF_DIGITS,
   parameter int SEG_W      = DEF_SEG_W,
   parameter int PERIOD_W   = DEF_PERIOD_W,
   parameter int MIN_PERIOD = DEF_MIN_PERIOD,
   parameter int CNT_W      = DEF_CNT_W
)(
   input  logic                      clk_clk,
   input  logic                      reset_reset,
   input  logic [DIGITS*SEG_W-1:0]   decode_in,
   input  logic [PERIOD_W-1:0]       period_in,
`ifdef HEX_BLINK_EN
   input  logic [DIGITS-1:0]         blink_mask,
`endif
   output logic [DIGITS*SEG_W-1:0]   seg_out,
   output logic                      frame_tick,
   output logic [CNT_W-1:0]          frame_cnt
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_COUNT = COUNT;
   localparam logic [1:0] S_LOAD  = LOAD;

   localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [SEG_W-1:0] BLANK    = {SEG_W{BLANK_DIGIT[0]}};

   logic [1:0]              state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DIGITS*SEG_W-1:0] shadow_q;
   logic [DIGITS*SEG_W-1:0] seg_q;
   logic                    tick_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    expire;
   logic                    run;
   logic                    period_zero;
   logic                    take_frame;
   logic                    load_last;
`ifdef HEX_BLINK_EN
   logic                    phase_q;
`endif

   assign period_zero = (period_in == '0);
   assign take_frame  = (state_q == S_COUNT) && expire;
   assign load_last   = (state_q == S_LOAD) && (idx_q == LAST_IDX);

   // Counter runs only while staying out of IDLE: it stays at zero on the
   // edge that leaves IDLE (so the first expiry is eff_period edges later)
   // and clears on the edge that enters IDLE.
   assign run = (state_q != S_IDLE) && (state_d != S_IDLE);

   hex_period_timer #(
      .PERIOD_W   (PERIOD_W),
      .MIN_PERIOD (MIN_PERIOD)
   ) u_timer (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .period_in   (period_in),
      .run         (run),
      .expire      (expire)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            idx_d = '0;
            if (!period_zero) begin
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (expire) begin
               state_d = S_LOAD;
               idx_d   = '0;
            end else if (period_zero) begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            idx_d = idx_q + IDX_W'(1);
            if (load_last) begin
               idx_d   = '0;
               state_d = period_zero ? S_IDLE : S_COUNT;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         tick_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         // Pulse lands in the first cycle every new digit is visible.
         tick_q  <= load_last;
         if (load_last) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (take_frame) begin
            shadow_q <= decode_in;
         end
      end
   end

`ifdef HEX_BLINK_EN
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         phase_q <= 1'b0;
      end else if (take_frame) begin
         phase_q <= ~phase_q;
      end
   end
`endif

   // One write port per digit, enabled when the load index reaches it.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [SEG_W-1:0] digit_val;

`ifdef HEX_BLINK_EN
      assign digit_val = (phase_q && blink_mask[gi]) ? BLANK
                                                     : shadow_q[gi*SEG_W +: SEG_W];
`else
      assign digit_val = shadow_q[gi*SEG_W +: SEG_W];
`endif

      always_ff @(posedge clk_clk) begin
         if (reset_reset) begin
            seg_q[gi*SEG_W +: SEG_W] <= BLANK;
         end else if ((state_q == S_LOAD) && (idx_q == IDX_W'(gi))) begin
            seg_q[gi*SEG_W +: SEG_W] <= digit_val;
         end
      end
   end

   assign seg_out    = seg_q;
   assign frame_tick = tick_q;
   assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_hex_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_hex_frame_sched
// Directed self-checking bench for hex_frame_sched (default geometry:
// 4 digits x 7 segments, 28-bit period, MIN_PERIOD 5, 16-bit frame count).
// Blink scenario is compiled only when HEX_BLINK_EN is defined.
// ---------------------------------------------------------------------------
module tb_hex_frame_sched;

   logic        clk_clk;
   logic        reset_reset;
   logic [27:0] decode_in;
   logic [27:0] period_in;
   logic [27:0] seg_out;
   logic        frame_tick;
   logic [15:0] frame_cnt;
`ifdef HEX_BLINK_EN
   logic [3:0]  blink_mask;
`endif

   int checks = 0;
   int errors = 0;

   hex_frame_sched dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .decode_in   (decode_in),
      .period_in   (period_in),
`ifdef HEX_BLINK_EN
      .blink_mask  (blink_mask),
`endif
      .seg_out     (seg_out),
      .frame_tick  (frame_tick),
      .frame_cnt   (frame_cnt)
   );

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the next frame_tick; n = negedges waited, 0 on timeout.
   task automatic wait_tick(input string tag, input int max, output int n);
      n = 0;
      for (int i = 1; i <= max; i++) begin
         @(negedge clk_clk);
         if (frame_tick) begin
            n = i;
            break;
         end
      end
      check({tag, "_seen"}, 32'(n != 0), 32'd1);
   endtask

   // Expected display after the low k digits of new_w replaced old_w.
   function automatic logic [27:0] partial(input logic [27:0] old_w,
                                           input logic [27:0] new_w, input int k);
      logic [27:0] m;
      m = 28'((32'd1 << (7 * k)) - 32'd1);
      return (old_w & ~m) | (new_w & m);
   endfunction

   initial begin
      int n;
      int ticks;
      reset_reset = 1'b1;
      decode_in   = 28'h0000000;
      period_in   = 28'd0;
`ifdef HEX_BLINK_EN
      blink_mask  = 4'b0000;
`endif

      // ---- reset state, stopped period ----
      repeat (3) @(negedge clk_clk);
      check("rst_seg", seg_out, 28'hFFFFFFF);
      check("rst_tick", frame_tick, 1'b0);
      check("rst_cnt", frame_cnt, 16'd0);
      reset_reset = 1'b0;
      ticks = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_clk);
         if (frame_tick) ticks++;
      end
      check("idle_ticks", ticks, 0);
      check("idle_seg", seg_out, 28'hFFFFFFF);
      check("idle_cnt", frame_cnt, 16'd0);
      $display("step idle: 100 cycles stopped");

      // ---- period 10, decode 0x1234567; k = edges after leaving IDLE ----
      decode_in = 28'h1234567;
      period_in = 28'd10;
      for (int k = 0; k <= 36; k++) begin
         @(negedge clk_clk);
         check($sformatf("p10_tick_k%0d", k), frame_tick, (k == 14 || k == 24 || k == 34));
         if (k >= 10 && k <= 14)
            check($sformatf("p10_seg_k%0d", k), seg_out, partial(28'hFFFFFFF, 28'h1234567, k - 10));
         if (k == 14) check("p10_cnt_first", frame_cnt, 16'd1);
      end
      check("p10_cnt_three", frame_cnt, 16'd3);
      $display("step p10: three frames of 0x1234567");

      // ---- period 2 floors to 5 ----
      period_in = 28'd2;
      wait_tick("p2_first", 20, n);
      wait_tick("p2_sp1", 20, n);
      check("p2_spacing1", n, 5);
      wait_tick("p2_sp2", 20, n);
      check("p2_spacing2", n, 5);
      $display("step p2: spacing floored to MIN_PERIOD");

      // ---- period 100, then 3 while counter = 50 ----
      period_in = 28'd100;   // counter is 4 in this tick cycle
      ticks = 0;
      for (int i = 0; i < 46; i++) begin
         @(negedge clk_clk);
         if (frame_tick) ticks++;
      end
      check("p100_no_tick", ticks, 0);
      period_in = 28'd3;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk_clk);
         check($sformatf("shrink_tick_k%0d", k), frame_tick, (k == 5));
      end
      wait_tick("shrink_sp", 20, n);
      check("shrink_spacing", n, 5);
      $display("step shrink: 100->3 at count 50");

      // ---- reset in the middle of LOAD after two digits ----
      period_in = 28'd10;    // counter 4 now, expiry on 6th edge
      decode_in = 28'h7654321;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_clk);
         if (k == 6) check("mid_seg_hold", seg_out, 28'h1234567);
         if (k == 7) check("mid_seg_d0", seg_out, partial(28'h1234567, 28'h7654321, 1));
         if (k == 8) check("mid_seg_d1", seg_out, partial(28'h1234567, 28'h7654321, 2));
      end
      reset_reset = 1'b1;
      period_in   = 28'd0;
      @(negedge clk_clk);
      check("mrst_seg", seg_out, 28'hFFFFFFF);
      check("mrst_cnt", frame_cnt, 16'd0);
      check("mrst_tick", frame_tick, 1'b0);
      reset_reset = 1'b0;
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_clk);
         if (frame_tick) ticks++;
      end
      check("mrst_no_tick", ticks, 0);
      check("mrst_seg_after", seg_out, 28'hFFFFFFF);
      $display("step midload reset: display blanked");

`ifdef HEX_BLINK_EN
      // ---- blink digit 0 ----
      decode_in  = 28'h0000000;
      blink_mask = 4'b0001;
      period_in  = 28'd10;
      wait_tick("blk_f1", 30, n);
      check("blk_seg_f1", seg_out, 28'h000007F);
      wait_tick("blk_f2", 20, n);
      check("blk_spacing", n, 10);
      check("blk_seg_f2", seg_out, 28'h0000000);
      wait_tick("blk_f3", 20, n);
      check("blk_seg_f3", seg_out, 28'h000007F);
      $display("step blink: digit 0 alternates");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_frame_sched.md
# hex_frame_sched

Frame scheduler between the Nios II PIO exports and the DE10 seven-segment displays. Samples the 28-bit decode word (4 digits × 7 segments, active-low) once per programmable frame period taken from the 28-bit period word. Writes the sampled word to the display register one digit per cycle. Reports each completed frame with a strobe and a frame counter, so firmware controls refresh rate instead of driving segments directly.

## Interface
Parameters:
- DIGITS, 4, number of digits
- SEG_W, 7, segments per digit
- PERIOD_W, 28, period word width
- MIN_PERIOD, 5, floor on effective period; must be ≥ DIGITS+1
- CNT_W, 16, frame counter width

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- decode_in  in  DIGITS*SEG_W  segment patterns from decode0 PIO; digit i = bits [i*SEG_W +: SEG_W]
- period_in  in  PERIOD_W  frame period in cycles from period0 PIO; 0 = stopped
- seg_out  out  DIGITS*SEG_W  registered segment drive, active-low
- frame_tick  out  1  one-cycle pulse per completed frame
- frame_cnt  out  CNT_W  completed-frame count, wraps
- blink_mask  in  DIGITS  per-digit blink enable; present only with HEX_BLINK_EN

## Operation
- Reset values: seg_out all ones (blank), frame_tick 0, frame_cnt 0, state IDLE, period counter 0, digit index 0, blink phase 0.
- eff_period = max(period_in, MIN_PERIOD). Evaluated live every cycle, not latched.
- States:
  - IDLE: counter held at 0; seg_out held. Leave to COUNT when period_in ≠ 0.
  - COUNT: counter increments each cycle. Expiry when counter ≥ eff_period−1:
    - counter clears;
    - shadow register loads decode_in;
    - go to LOAD with index 0.
    - If period_in = 0 and no expiry this cycle, go to IDLE and clear the counter.
  - LOAD: seg_out digit[index] ← shadow digit[index]; index increments. The period counter keeps running, so frame spacing is exactly eff_period.
    - After digit DIGITS−1, return to COUNT, or go to IDLE if period_in = 0.
- Expiry comparison uses ≥, so a period_in decrease below the current count forces expiry on the next cycle.
- MIN_PERIOD > DIGITS guarantees LOAD always completes before the next expiry.
- frame_cnt increments by 1 modulo 2^CNT_W once per completed LOAD.
- decode_in changes outside the expiry cycle have no effect until the next expiry.
- Reset mid-LOAD: all outputs return to reset values; partially loaded digits are blanked.

## Timing
- Edge E = expiry edge: shadow captures decode_in.
- Digit i is written at edge E+1+i and visible from the cycle after that edge.
- frame_tick is high for exactly the one cycle following edge E+DIGITS, i.e. the first cycle all new digits are visible. frame_cnt updates on the same edge.
- First expiry occurs eff_period edges after leaving IDLE.
- Steady-state frame_tick spacing = eff_period cycles.

## Configuration
- HEX_BLINK_EN defined:
  - blink_mask port exists.
  - blink phase toggles at every expiry.
  - While phase = 1, LOAD writes all ones to every digit whose mask bit is set; other digits load normally.
  - With period P, blinking digits alternate shown/blank every P cycles.
- HEX_BLINK_EN undefined: no blink_mask port, no phase register; every digit always loads the shadow value.

## Structure
- Package hex_sched_pkg holds:
  - DIGITS, SEG_W, PERIOD_W defaults;
  - BLANK_DIGIT constant (all ones);
  - state enum {IDLE, COUNT, LOAD}.
- Sub-module hex_period_timer: period counter plus expiry compare.
  - Inputs: period_in, run.
  - Output: expire pulse.
  - Counter clears when run = 0.

## Test plan
- Reset with period_in=0, decode_in=0x0000000 → seg_out=0xFFFFFFF, frame_tick never pulses over 100 cycles, frame_cnt=0.
- period_in=10, decode_in=0x1234567 → digits load on 4 consecutive edges. frame_tick pulses every 10 cycles, first pulse 14 cycles after leaving IDLE. frame_cnt=3 after 3 frames.
- period_in=2 → behaves as 5 (MIN_PERIOD); frame_tick spacing = 5 cycles.
- period_in changed 100→3 while counter=50 → expiry on the next edge, then 5-cycle spacing.
- Assert reset_reset during LOAD after 2 digits → next cycle seg_out=0xFFFFFFF, frame_cnt=0, no frame_tick.
- HEX_BLINK_EN, blink_mask=4'b0001, period 10, decode_in=0x0000000 → digit 0 alternates 0x00/0x7F every frame; digits 1–3 stay 0x00.
